// File: rtl/csa_rr_arbiter.sv
// csa_rr_arbiter: shares one 32-bit carry-select adder between NREQ
// requesters. Round-robin arbitration with a chain lock that holds the
// grant on one requester and forwards the carry between beats, so that
// requester can build wider sums. Two-stage pipeline: operands are
// registered at accept, and the result is registered one cycle later.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   req         per-requester request, held until granted
//   req_a/req_b packed operands, slice i = bits [32i+31:32i]
//   req_cin     carry-in, used on unchained ops and on the first chain beat
//   req_chain   1 = another beat of this multi-word add follows
//   gnt         one-hot combinational grant
//   resp_valid  one-cycle pulse per accepted op, two cycles after accept
//   resp_id     requester that owns the result
//   resp_sum    A+B+cin mod 2^32 (held while resp_valid=0)
//   resp_cout   carry out of bit 31 (held while resp_valid=0)
//   busy        lock | s1_valid | resp_valid

// bit32_CSA: 32-bit carry-select adder built from eight 4-bit blocks.
// Each block precomputes its sum for both carry-in values, and the
// incoming block carry only drives the select. sum[39:32] is always 0.
module bit32_CSA (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [39:0] sum,
  output logic        cout
);

  logic [4:0]  r0 [8];
  logic [4:0]  r1 [8];
  logic [31:0] sum_lo;
  logic        c;

  for (genvar k = 0; k < 8; k++) begin : g_blk
    assign r0[k] = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
    assign r1[k] = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + 5'd1;
  end

  always_comb begin
    c      = cin;
    sum_lo = '0;
    for (int k = 0; k < 8; k++) begin
      sum_lo[4*k +: 4] = c ? r1[k][3:0] : r0[k][3:0];
      c                = c ? r1[k][4]   : r0[k][4];
    end
  end

  assign sum  = {8'h00, sum_lo};
  assign cout = c;

endmodule

module csa_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_chain,
  output logic [NREQ-1:0]   gnt,
  output logic              resp_valid,
  output logic [ID_W-1:0]   resp_id,
  output logic [31:0]       resp_sum,
  output logic              resp_cout,
  output logic              busy
);

  logic [ID_W-1:0] ptr;
  logic            lock;
  logic [ID_W-1:0] lock_id;
  logic            carry_save;

  logic            s1_valid;
  logic [31:0]     s1_a;
  logic [31:0]     s1_b;
  logic            s1_cin;
  logic [ID_W-1:0] s1_id;

  logic [39:0]     add_sum;
  logic            add_cout;
  logic            unused_add_hi;

  logic            found;
  logic [ID_W-1:0] idx;

  logic            acc;
  logic [ID_W-1:0] acc_id;
  logic [ID_W-1:0] ptr_inc;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic            cin_req;
  logic            chain_sel;
  logic            cin_eff;

  bit32_CSA u_add (
    .a    (s1_a),
    .b    (s1_b),
    .cin  (s1_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign unused_add_hi = ^add_sum[39:32];

  // While locked, only the lock owner may be granted, even when it is idle.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (rst_n) begin
      if (lock) begin
        gnt[lock_id] = req[lock_id];
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = ID_W'((int'(ptr) + k) % NREQ);
          if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

  // gnt is one-hot, so OR-ing the selected slices is a clean mux.
  always_comb begin
    acc_id    = '0;
    ptr_inc   = '0;
    a_sel     = '0;
    b_sel     = '0;
    cin_req   = 1'b0;
    chain_sel = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        acc_id    = ID_W'(k);
        ptr_inc   = ID_W'((k + 1) % NREQ);
        a_sel     = req_a[32*k +: 32];
        b_sel     = req_b[32*k +: 32];
        cin_req   = req_cin[k];
        chain_sel = req_chain[k];
      end
    end
  end

  assign acc = |(req & gnt);

  // A locked beat takes the previous beat's carry: straight from the adder
  // if that beat is still in stage 1, otherwise from the saved copy.
  assign cin_eff = lock ? (s1_valid ? add_cout : carry_save) : cin_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      lock       <= 1'b0;
      lock_id    <= '0;
      carry_save <= 1'b0;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_cin     <= 1'b0;
      s1_id      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_a   <= a_sel;
        s1_b   <= b_sel;
        s1_cin <= cin_eff;
        s1_id  <= acc_id;
        if (chain_sel) begin
          lock    <= 1'b1;
          lock_id <= acc_id;
        end else begin
          lock <= 1'b0;
          ptr  <= ptr_inc;
        end
      end

      if (s1_valid) begin
        carry_save <= add_cout;
      end

      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_sum  <= add_sum[31:0];
        resp_cout <= add_cout;
        resp_id   <= s1_id;
      end
    end
  end

  assign busy = lock | s1_valid | resp_valid;

endmodule

// File: tb/tb_csa_rr_arbiter.sv
module tb_csa_rr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_cin;
  logic [3:0]   req_chain;
  logic [3:0]   gnt;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sum;
  logic         resp_cout;
  logic         busy;

  int checks = 0;
  int passes = 0;

  // reference model state
  int          m_ptr = 0;
  logic        m_lock = 1'b0;
  int          m_lock_id = 0;
  logic        m_carry = 1'b0;
  logic [3:0]  m_acc = '0;
  logic        p1_v = 1'b0;
  logic [1:0]  p1_id = '0;
  logic [31:0] p1_sum = '0;
  logic        p1_cout = 1'b0;
  logic        e_rv = 1'b0;
  logic [1:0]  e_id = '0;
  logic [31:0] e_sum = '0;
  logic        e_cout = 1'b0;

  csa_rr_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_chain  (req_chain),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    int j;
    g = '0;
    if (!rst_n) return g;
    if (m_lock) begin
      g[m_lock_id] = req[m_lock_id];
      return g;
    end
    for (int k = 0; k < 4; k++) begin
      j = (m_ptr + k) % 4;
      if (req[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Advances the model across the coming clock edge using the inputs now driven.
  task automatic model_advance();
    logic [3:0]  g;
    logic [32:0] s;
    logic        c;
    if (!rst_n) begin
      m_ptr = 0; m_lock = 1'b0; m_lock_id = 0; m_carry = 1'b0; m_acc = '0;
      p1_v = 1'b0; e_rv = 1'b0; e_id = '0; e_sum = '0; e_cout = 1'b0;
    end else begin
      g = model_gnt();
      e_rv = p1_v;
      if (p1_v) begin
        e_id = p1_id; e_sum = p1_sum; e_cout = p1_cout;
      end
      m_acc = req & g;
      p1_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_acc[i]) begin
          c = m_lock ? m_carry : req_cin[i];
          s = {1'b0, req_a[32*i +: 32]} + {1'b0, req_b[32*i +: 32]} + {32'b0, c};
          p1_v = 1'b1; p1_id = 2'(i); p1_sum = s[31:0]; p1_cout = s[32];
          m_carry = s[32];
          if (req_chain[i]) begin
            m_lock = 1'b1; m_lock_id = i;
          end else begin
            m_lock = 1'b0; m_ptr = (i + 1) % 4;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic chain);
    req[i] = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i] = cin;
    req_chain[i] = chain;
  endtask

  task automatic idle_all();
    req = '0; req_cin = '0; req_chain = '0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF;
    #2;
    checks++; if (gnt !== 4'b0000) $display("FAIL rst_gnt_low: got %b expected 0000", gnt); else passes++;
    cyc(); cyc();
    #2;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", resp_valid); else passes++;
    checks++; if (resp_sum !== 32'h0) $display("FAIL rst_sum: got %h expected 0", resp_sum); else passes++;
    checks++; if (resp_id !== 2'd0 || resp_cout !== 1'b0) $display("FAIL rst_id_cout: got %0d/%b expected 0/0", resp_id, resp_cout); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passes++;
    rst_n = 1'b1; idle_all();
    cyc();
  endtask

  task automatic test_single();
    set_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #2;
    checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b expected 0001", gnt); else passes++;
    cyc(); idle_all(); #2;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL single_t1: got valid %b busy %b expected 0 1", resp_valid, busy); else passes++;
    cyc(); #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) $display("FAIL single_t2_valid_id: got %b/%0d expected 1/0", resp_valid, resp_id); else passes++;
    checks++; if (resp_sum !== 32'h0 || resp_cout !== 1'b1) $display("FAIL single_t2_sum: got %h/%b expected 00000000/1", resp_sum, resp_cout); else passes++;
    cyc(); #2;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_t3: got valid %b busy %b expected 0 0", resp_valid, busy); else passes++;
    checks++; if (resp_cout !== 1'b1) $display("FAIL single_hold: got cout %b expected 1", resp_cout); else passes++;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  eg;
    logic [31:0] es;
    int id;
    rst_n = 1'b0; idle_all(); cyc(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 32'h1000_0000 * i + 1, i, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      #2;
      eg = 4'b0001 << (k % 4);
      checks++; if (gnt !== eg) $display("FAIL b2b_gnt k=%0d: got %b expected %b", k, gnt, eg); else passes++;
      if (k >= 2) begin
        id = (k - 2) % 4;
        es = 32'h1000_0000 * id + 1 + id;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'(id) || resp_sum !== es)
          $display("FAIL b2b_resp k=%0d: got %b/%0d/%h expected 1/%0d/%h", k, resp_valid, resp_id, resp_sum, id, es);
        else passes++;
      end
      cyc();
    end
    idle_all(); #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) $display("FAIL b2b_drain0: got %b/%0d expected 1/0", resp_valid, resp_id); else passes++;
    cyc(); #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1) $display("FAIL b2b_drain1: got %b/%0d expected 1/1", resp_valid, resp_id); else passes++;
    cyc(); #2;
    checks++; if (resp_valid !== 1'b0) $display("FAIL b2b_end: got %b expected 0", resp_valid); else passes++;
    cyc();
  endtask

  task automatic test_chain_lock();
    idle_all();
    set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    set_op(1, 32'h3, 32'h4, 1'b0, 1'b0);
    #2;
    checks++; if (gnt !== 4'b0100) $display("FAIL lock_beat1_gnt: got %b expected 0100", gnt); else passes++;
    cyc();
    set_op(2, 32'h0, 32'h0, 1'b1, 1'b0);
    #2;
    checks++; if (gnt !== 4'b0100) $display("FAIL lock_beat2_gnt: got %b expected 0100", gnt); else passes++;
    cyc();
    req[2] = 1'b0; #2;
    checks++; if (gnt !== 4'b0010) $display("FAIL lock_release_gnt: got %b expected 0010", gnt); else passes++;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 32'h0 || resp_cout !== 1'b1)
      $display("FAIL lock_resp1: got %b/%0d/%h/%b expected 1/2/00000000/1", resp_valid, resp_id, resp_sum, resp_cout); else passes++;
    cyc();
    req[1] = 1'b0; #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 32'h1 || resp_cout !== 1'b0)
      $display("FAIL lock_resp2: got %b/%0d/%h/%b expected 1/2/00000001/0", resp_valid, resp_id, resp_sum, resp_cout); else passes++;
    cyc(); #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 32'h7)
      $display("FAIL lock_resp3: got %b/%0d/%h expected 1/1/00000007", resp_valid, resp_id, resp_sum); else passes++;
    cyc(); cyc();
  endtask

  task automatic test_chain_gap();
    idle_all();
    set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    set_op(1, 32'h9, 32'h1, 1'b0, 1'b0);
    #2;
    checks++; if (gnt !== 4'b0100) $display("FAIL gap_beat1_gnt: got %b expected 0100", gnt); else passes++;
    cyc();
    req[2] = 1'b0; #2;
    checks++; if (gnt !== 4'b0000) $display("FAIL gap_gnt0: got %b expected 0000", gnt); else passes++;
    cyc(); #2;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL gap_gnt1: got %b busy %b expected 0000 1", gnt, busy); else passes++;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 32'h0 || resp_cout !== 1'b1)
      $display("FAIL gap_resp1: got %b/%0d/%h/%b expected 1/2/00000000/1", resp_valid, resp_id, resp_sum, resp_cout); else passes++;
    cyc();
    set_op(2, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    checks++; if (gnt !== 4'b0100) $display("FAIL gap_beat2_gnt: got %b expected 0100", gnt); else passes++;
    cyc();
    req[2] = 1'b0; #2;
    checks++; if (gnt !== 4'b0010) $display("FAIL gap_release_gnt: got %b expected 0010", gnt); else passes++;
    cyc();
    req[1] = 1'b0; #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 32'h1 || resp_cout !== 1'b0)
      $display("FAIL gap_resp2: got %b/%0d/%h/%b expected 1/2/00000001/0", resp_valid, resp_id, resp_sum, resp_cout); else passes++;
    cyc(); #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 32'hA)
      $display("FAIL gap_resp3: got %b/%0d/%h expected 1/1/0000000a", resp_valid, resp_id, resp_sum); else passes++;
    cyc(); cyc();
  endtask

  task automatic test_reset_flush();
    idle_all();
    set_op(3, 32'h5, 32'h7, 1'b0, 1'b0);
    #2;
    checks++; if (gnt !== 4'b1000) $display("FAIL flush_gnt: got %b expected 1000", gnt); else passes++;
    cyc();
    rst_n = 1'b0; idle_all(); #2;
    checks++; if (gnt !== 4'b0000) $display("FAIL flush_rst_gnt: got %b expected 0000", gnt); else passes++;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, $urandom(), $urandom(), 1'b0, 1'b0);
    #2;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_no_resp: got valid %b busy %b expected 0 0", resp_valid, busy); else passes++;
    checks++; if (resp_sum !== 32'h0 || resp_id !== 2'd0 || resp_cout !== 1'b0)
      $display("FAIL flush_outs: got %h/%0d/%b expected 00000000/0/0", resp_sum, resp_id, resp_cout); else passes++;
    checks++; if (gnt !== 4'b0001) $display("FAIL flush_ptr0: got %b expected 0001", gnt); else passes++;
    for (int k = 0; k < 4; k++) cyc();
    idle_all();
    for (int k = 0; k < 3; k++) cyc();
  endtask

  task automatic test_cin();
    idle_all();
    set_op(1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
    #2;
    checks++; if (gnt !== 4'b0010) $display("FAIL cin_gnt0: got %b expected 0010", gnt); else passes++;
    cyc();
    set_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    #2;
    checks++; if (gnt !== 4'b0010) $display("FAIL cin_gnt1: got %b expected 0010", gnt); else passes++;
    cyc();
    idle_all(); #2;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 32'h8000_0000 || resp_cout !== 1'b0)
      $display("FAIL cin_resp0: got %b/%0d/%h/%b expected 1/1/80000000/0", resp_valid, resp_id, resp_sum, resp_cout); else passes++;
    cyc(); #2;
    checks++; if (resp_valid !== 1'b1 || resp_sum !== 32'h0 || resp_cout !== 1'b1)
      $display("FAIL cin_resp1: got %b/%h/%b expected 1/00000000/1", resp_valid, resp_sum, resp_cout); else passes++;
    cyc(); cyc();
  endtask

  task automatic test_random();
    int beats_left [4];
    logic [3:0] eg;
    logic       eb;
    for (int i = 0; i < 4; i++) beats_left[i] = 0;
    idle_all();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) begin
          if (beats_left[i] == 0 && $urandom_range(0, 9) < 3) beats_left[i] = $urandom_range(1, 4);
          if (beats_left[i] > 0 && $urandom_range(0, 1) == 1)
            set_op(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), beats_left[i] > 1);
        end
      end
      #2;
      eg = model_gnt();
      eb = m_lock | p1_v | e_rv;
      checks++; if (gnt !== eg) $display("FAIL rnd_gnt n=%0d: got %b expected %b", n, gnt, eg); else passes++;
      checks++; if (resp_valid !== e_rv || resp_id !== e_id)
        $display("FAIL rnd_valid_id n=%0d: got %b/%0d expected %b/%0d", n, resp_valid, resp_id, e_rv, e_id); else passes++;
      checks++; if (resp_sum !== e_sum || resp_cout !== e_cout)
        $display("FAIL rnd_sum n=%0d: got %h/%b expected %h/%b", n, resp_sum, resp_cout, e_sum, e_cout); else passes++;
      checks++; if (busy !== eb) $display("FAIL rnd_busy n=%0d: got %b expected %b", n, busy, eb); else passes++;
      cyc();
      for (int i = 0; i < 4; i++) begin
        if (m_acc[i]) begin
          req[i] = 1'b0;
          beats_left[i] = beats_left[i] - 1;
        end
      end
    end
    idle_all();
    cyc(); cyc(); cyc();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    idle_all();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_chain_lock();
    test_chain_gap();
    test_reset_flush();
    test_cin();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
